adpt_dequantizer: RTL and testbench

ADPT_DEQUANTIZER -- requirements
Module: adpt_dequantizer

---
 rtl/adpt_dequantizer_if.sv | 15 +
 rtl/adpt_dequantizer.sv | 164 ++++++++++++++++
 tb/tb_adpt_dequantizer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adpt_dequantizer_if.sv
// Register bus: word addressed; a write takes effect on the edge where wr=1.
// A read issued on edge k returns rdata together with a one-cycle rvalid after edge k.
interface rwbus_interface;
    logic        clk;
    logic [31:0] baseaddr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output clk, baseaddr, addr, wdata, wr, rd, input rdata, rvalid);
    modport slave  (input clk, baseaddr, addr, wdata, wr, rd, output rdata, rvalid);
endinterface

// File: rtl/adpt_dequantizer.sv
// Purpose: adaptive-step dequantizer, dat_out = sat((2c+1)*step), step tuned from the saturation rate per window.
// Latency: a code accepted on edge k appears on dat_out with valid after edge k+2; full throughput.
// Backpressure: none; every cycle with we=1 is accepted, and register reads always complete in one cycle.
module adpt_dequantizer #(
    parameter logic [31:0] ID        = 32'h12345679,
    parameter int          N_dig_in  = 3,
    parameter int          N_dig_out = 13
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic signed [N_dig_in-1:0]  dat_in,
    input  logic                        we,
    output logic signed [N_dig_out-1:0] dat_out,
    output logic                        valid,
    rwbus_interface.slave               bus
);
    localparam int PW = N_dig_in + N_dig_out + 1;
    localparam int SW = N_dig_out - 1;
    localparam logic [SW-1:0] STEP_MAX = '1;
    localparam logic [SW-1:0] STEP_ONE = SW'(1);
    localparam logic [SW-1:0] STEP_RST = SW'(1) << (N_dig_out - N_dig_in - 1);
    localparam logic signed [PW-1:0] OMAX = {{(PW-N_dig_out+1){1'b0}}, {(N_dig_out-1){1'b1}}};
    localparam logic signed [PW-1:0] OMIN = {{(PW-N_dig_out+1){1'b1}}, {(N_dig_out-1){1'b0}}};
    localparam logic signed [N_dig_in-1:0] CMIN = {1'b1, {(N_dig_in-1){1'b0}}};
    localparam logic signed [N_dig_in-1:0] CMAX = {1'b0, {(N_dig_in-1){1'b1}}};

    // datapath pipeline
    logic                        s0_vld, s1_vld;
    logic signed [N_dig_in-1:0]  s0_code;
    logic [SW-1:0]               s0_step;
    logic signed [PW-1:0]        s1_prod, odd_x, step_x;
    logic [N_dig_out-1:0]        sat_val;

    // registers and window state
    logic          auto_en;
    logic [SW-1:0] step;
    logic [15:0]   win, sat_lo, sat_hi, status;
    logic [15:0]   samp_cnt, sat_cnt;

    assign odd_x  = PW'($signed({s0_code, 1'b1}));
    assign step_x = PW'($signed({1'b0, s0_step}));

    always_comb begin
        sat_val = s1_prod[N_dig_out-1:0];
        if (s1_prod > OMAX)      sat_val = {1'b0, {(N_dig_out-1){1'b1}}};
        else if (s1_prod < OMIN) sat_val = {1'b1, {(N_dig_out-1){1'b0}}};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s0_vld  <= 1'b0;
            s0_code <= '0;
            s0_step <= '0;
            s1_vld  <= 1'b0;
            s1_prod <= '0;
            valid   <= 1'b0;
            dat_out <= '0;
        end else begin
            s0_vld <= we;
            if (we) begin
                s0_code <= dat_in;
                s0_step <= step;
            end
            s1_vld <= s0_vld;
            if (s0_vld) s1_prod <= odd_x * step_x;
            valid <= s1_vld;
            if (s1_vld) dat_out <= sat_val;
        end
    end

    // bus decode: the block occupies 8 words above baseaddr
    logic [31:0] off;
    logic        in_rng, wr_ctrl, wr_step, wr_win, wr_sat, win_clr, bus_override;
    logic [31:0] rd_mux;

    assign off     = bus.addr - bus.baseaddr;
    assign in_rng  = (off[31:3] == '0);
    assign wr_ctrl = bus.wr && in_rng && (off[2:0] == 3'd1);
    assign wr_step = bus.wr && in_rng && (off[2:0] == 3'd2);
    assign wr_win  = bus.wr && in_rng && (off[2:0] == 3'd3);
    assign wr_sat  = bus.wr && in_rng && (off[2:0] == 3'd4);
    assign win_clr = wr_ctrl && bus.wdata[1];
    assign bus_override = wr_step || wr_win || win_clr;

    always_comb begin
        rd_mux = '0;
        case (off[2:0])
            3'd0: rd_mux = ID;
            3'd1: rd_mux = {31'd0, auto_en};
            3'd2: rd_mux = {{(32-SW){1'b0}}, step};
            3'd3: rd_mux = {16'd0, win};
            3'd4: rd_mux = {sat_hi, sat_lo};
            3'd5: rd_mux = {16'd0, status};
            default: rd_mux = '0;
        endcase
    end

    // window bookkeeping and step adaptation
    logic          is_sat, win_end;
    logic [15:0]   win_eff, sat_next;
    logic [SW-1:0] delta, step_up, step_dn, wr_step_val;
    logic [SW:0]   up_sum;

    assign is_sat   = (dat_in == CMIN) || (dat_in == CMAX);
    assign win_eff  = (win == 16'd0) ? 16'd1 : win;
    assign win_end  = we && (({1'b0, samp_cnt} + 17'd1) >= {1'b0, win_eff});
    assign sat_next = sat_cnt + {15'd0, is_sat};
    assign delta    = ((step >> 3) == '0) ? STEP_ONE : (step >> 3);
    assign up_sum   = {1'b0, step} + {1'b0, delta};
    assign step_up  = (up_sum > {1'b0, STEP_MAX}) ? STEP_MAX : up_sum[SW-1:0];
    assign step_dn  = (step <= delta) ? STEP_ONE : (step - delta);
    assign wr_step_val = (bus.wdata[SW-1:0] == '0) ? STEP_ONE : bus.wdata[SW-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            auto_en  <= 1'b0;
            step     <= STEP_RST;
            win      <= 16'd1024;
            sat_lo   <= 16'd16;
            sat_hi   <= 16'd256;
            status   <= '0;
            samp_cnt <= '0;
            sat_cnt  <= '0;
        end else begin
            if (wr_ctrl) auto_en <= bus.wdata[0];
            if (wr_win)  win <= bus.wdata[15:0];
            if (wr_sat) begin
                sat_lo <= bus.wdata[15:0];
                sat_hi <= bus.wdata[31:16];
            end
            // a register write in the window-end cycle discards that window's result
            if (wr_step) begin
                step <= wr_step_val;
            end else if (win_end && !bus_override && auto_en) begin
                if (sat_next > sat_hi)      step <= step_up;
                else if (sat_next < sat_lo) step <= step_dn;
            end
            if (wr_win || win_clr) begin
                samp_cnt <= '0;
                sat_cnt  <= '0;
            end else if (win_end) begin
                if (!bus_override) status <= sat_next;
                samp_cnt <= '0;
                sat_cnt  <= '0;
            end else if (we) begin
                samp_cnt <= samp_cnt + 16'd1;
                sat_cnt  <= sat_next;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            bus.rvalid <= bus.rd && in_rng;
            if (bus.rd) bus.rdata <= in_rng ? rd_mux : 32'd0;
        end
    end

    logic unused_bus_clk;
    assign unused_bus_clk = bus.clk;
endmodule

// File: tb/tb_adpt_dequantizer.sv
// Bench for adpt_dequantizer: fixed vectors, directed window/adaptation sequences and a randomized run
// against a per-sample reference model of the reconstruction and step adaptation rules.
module tb_adpt_dequantizer;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic signed [2:0] dat_in = '0;
    logic              we = 1'b0;
    logic signed [12:0] dat_out;
    logic              valid;

    rwbus_interface bus();
    assign bus.clk = clk;
    assign bus.baseaddr = BASE;

    adpt_dequantizer dut (
        .clk(clk), .resetn(resetn), .dat_in(dat_in), .we(we),
        .dat_out(dat_out), .valid(valid), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // reference model state
    int m_step, m_win, m_lo, m_hi, m_auto, m_samp, m_sat, m_status;

    function automatic void m_reset();
        m_step = 512; m_win = 1024; m_lo = 16; m_hi = 256; m_auto = 0;
        m_samp = 0; m_sat = 0; m_status = 0;
    endfunction

    function automatic int recon(int c, int s);
        int p;
        p = (2 * c + 1) * s;
        if (p > 4095)  return 4095;
        if (p < -4096) return -4096;
        return p;
    endfunction

    function automatic void m_accept(int c);
        int d, lim;
        m_samp++;
        if (c == -4 || c == 3) m_sat++;
        lim = (m_win == 0) ? 1 : m_win;
        if (m_samp >= lim) begin
            m_status = m_sat;
            if (m_auto != 0) begin
                d = (m_step / 8 < 1) ? 1 : m_step / 8;
                if (m_sat > m_hi)      m_step = (m_step + d > 4095) ? 4095 : m_step + d;
                else if (m_sat < m_lo) m_step = (m_step - d < 1) ? 1 : m_step - d;
            end
            m_samp = 0; m_sat = 0;
        end
    endfunction

    function automatic void m_write(int off, logic [31:0] d);
        case (off)
            1: begin m_auto = d[0]; if (d[1]) begin m_samp = 0; m_sat = 0; end end
            2: m_step = (d % 4096 == 0) ? 1 : int'(d % 4096);
            3: begin m_win = d[15:0]; m_samp = 0; m_sat = 0; end
            4: begin m_lo = d[15:0]; m_hi = d[31:16]; end
            default: ;
        endcase
    endfunction

    // output scoreboard: expected value plus the cycle on which it must appear
    typedef struct { int due; int val; } exp_t;
    exp_t q[$];
    int mon_last = 0;

    always @(negedge clk) begin
        if (resetn) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                check("valid_pulse", valid, 1);
                check("dat_out", $signed(dat_out), q[0].val);
                mon_last = q[0].val;
                void'(q.pop_front());
            end else begin
                check("valid_idle", valid, 0);
                check("dat_out_hold", $signed(dat_out), mon_last);
            end
        end
    end

    task automatic send(input int c, input int exp_v);
        dat_in = c[2:0];
        we = 1'b1;
        q.push_back('{cyc + 3, exp_v});
        m_accept(c);
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic send_m(input int c);
        send(c, recon(c, m_step));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int off, input logic [31:0] d);
        bus.addr = BASE + off; bus.wdata = d; bus.wr = 1'b1;
        m_write(off, d);
        @(posedge clk); #1;
        bus.wr = 1'b0;
    endtask

    task automatic bus_read(input int off, output logic [31:0] d);
        bus.addr = BASE + off; bus.rd = 1'b1;
        @(posedge clk); #1;
        bus.rd = 1'b0;
        check("rd_rvalid", bus.rvalid, 1);
        d = bus.rdata;
    endtask

    task automatic read_check(input string nm, input int off, input longint exp);
        logic [31:0] d;
        bus_read(off, d);
        check(nm, d, exp);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 10) begin @(posedge clk); n++; end
        #1;
        check("drain_pending", q.size(), 0);
        q.delete();
    endtask

    typedef struct { int code; int step_wr; int exp; } vec_t;
    vec_t tbl[12];

    initial begin
        logic [31:0] st0;
        tbl[0]  = '{ 3, 4095,  4095};
        tbl[1]  = '{-4, 4095, -4096};
        tbl[2]  = '{ 0,    1,     1};
        tbl[3]  = '{-4,    1,    -7};
        tbl[4]  = '{ 2,  100,   500};
        tbl[5]  = '{-1, 4095, -4095};
        tbl[6]  = '{-3, 2000, -4096};
        tbl[7]  = '{ 1, 2000,  4095};
        tbl[8]  = '{-2,  600, -1800};
        tbl[9]  = '{ 3,  585,  4095};
        tbl[10] = '{-4,  586, -4096};
        tbl[11] = '{ 0, 8199,     7};

        bus.addr = '0; bus.wdata = '0; bus.wr = 1'b0; bus.rd = 1'b0;
        m_reset();
        idle(3);
        check("reset_dat_out", $signed(dat_out), 0);
        check("reset_valid", valid, 0);
        resetn = 1'b1;
        idle(1);

        // reset register values
        read_check("rd_id", 0, 32'h12345679);
        read_check("rd_step_rst", 2, 512);
        read_check("rd_ctrl_rst", 1, 0);
        read_check("rd_win_rst", 3, 1024);
        read_check("rd_sat_rst", 4, (256 << 16) | 16);
        read_check("rd_status_rst", 5, 0);
        read_check("rd_unmapped", 7, 0);

        // back-to-back codes at the reset step
        send(-4, -3584); send(-1, -512); send(0, 512); send(3, 3584);
        drain();

        // fixed vectors; each step write lands while the previous code is still in flight
        for (int i = 0; i < 12; i++) begin
            bus_write(2, tbl[i].step_wr);
            send(tbl[i].code, tbl[i].exp);
        end
        drain();
        read_check("rd_step_trunc", 2, 7);

        // saturation-driven increase, then decrease
        bus_write(2, 512);
        bus_write(3, 8);
        bus_write(4, (4 << 16) | 16);
        bus_write(1, 1);
        for (int i = 0; i < 8; i++) send(3, 3584);
        drain();
        read_check("rd_status_8", 5, 8);
        read_check("rd_step_up", 2, 576);
        read_check("rd_ctrl_auto", 1, 1);
        bus_write(4, (4 << 16) | 1);
        for (int i = 0; i < 8; i++) send(0, 576);
        drain();
        read_check("rd_status_0", 5, 0);
        read_check("rd_step_down", 2, 504);
        bus_write(5, 32'hFFFF);
        read_check("rd_status_ro", 5, 0);

        // step floor
        bus_write(2, 0);
        read_check("rd_step_zero", 2, 1);
        bus_write(3, 1);
        bus_write(4, (256 << 16) | 1);
        send(0, 1);
        drain();
        read_check("rd_step_floor", 2, 1);

        // step write in the same cycle as a window end
        bus_write(1, 3);
        bus_write(3, 4);
        bus_write(4, 0);
        bus_read(5, st0);
        for (int i = 0; i < 3; i++) send_m(3);
        dat_in = 3'sd3; we = 1'b1;
        bus.addr = BASE + 2; bus.wdata = 1000; bus.wr = 1'b1;
        q.push_back('{cyc + 3, recon(3, m_step)});
        m_step = 1000; m_samp = 0; m_sat = 0;
        @(posedge clk); #1;
        we = 1'b0; bus.wr = 1'b0;
        drain();
        read_check("rd_step_coinc", 2, 1000);
        read_check("rd_status_coinc", 5, st0);
        send(3, 4095); send(0, 1000); send(0, 1000); send(0, 1000);
        drain();
        read_check("rd_status_fresh", 5, 1);
        read_check("rd_step_fresh", 2, 1125);

        // randomized run against the model
        bus_write(3, $urandom_range(0, 12));
        bus_write(4, ($urandom_range(0, 8) << 16) | $urandom_range(0, 4));
        bus_write(1, 1);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r == 0)      bus_write(2, $urandom_range(0, 4200));
            else if (r == 1) bus_write(3, $urandom_range(0, 12));
            else if (r < 8)  idle(1);
            else             send_m(int'($urandom_range(0, 7)) - 4);
        end
        drain();
        read_check("rd_step_rand", 2, m_step);
        read_check("rd_status_rand", 5, m_status);

        // reset with codes in flight
        send_m(3);
        send_m(-4);
        resetn = 1'b0;
        q.delete();
        mon_last = 0;
        m_reset();
        idle(1);
        check("midrst_valid", valid, 0);
        check("midrst_dat_out", $signed(dat_out), 0);
        resetn = 1'b1;
        idle(6);
        read_check("rd_step_after_rst", 2, 512);
        read_check("rd_status_after_rst", 5, 0);
        send(1, 1536);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
